// File: rtl/uart_wb_master.sv
// Single-access Wishbone initiator for the UART register port.
// Takes one command, runs one classic cycle (ack or timeout), then returns a response.
module uart_wb_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT    = 16   // 2..255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  // Command channel
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [7:0]            cmd_dat_i,
  // Response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [7:0]            rsp_dat_o,
  output logic                  rsp_err_o,
  // Wishbone initiator
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StBus, StRsp} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]            dat_q, dat_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  // Low through reset, high from the first clock after release; gates cmd_ready_o.
  logic                  live_q;

  logic                  in_bus;
  logic [1:0]            lane;
  logic [7:0]            rd_byte;

  assign in_bus  = (state_q == StBus);
  assign lane    = adr_q[1:0];
  assign rd_byte = wb_dat_i[{lane, 3'b000} +: 8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack takes priority over an expiring timeout.
        if (wb_ack_i) begin
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? 8'h00 : rd_byte;
          state_d   = StRsp;
        end else if (cnt_q == CntLast) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = 8'h00;
          state_d   = StRsp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready_o = (state_q == StIdle) && live_q;
  assign busy_o      = (state_q != StIdle);

  assign wb_cyc_o = in_bus;
  assign wb_stb_o = in_bus;
  assign wb_we_o  = in_bus && we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = in_bus ? (4'b0001 << lane) : 4'b0000;
  assign wb_dat_o = (in_bus && we_q) ? {4{dat_q}} : 32'h0;

  assign rsp_valid_o = (state_q == StRsp);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: directed cases plus randomized accesses
// compared against a transaction-level model of the expected bus and response.
module tb_uart_wb_master;

  localparam int unsigned AW = 5;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [7:0]    cmd_dat;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [7:0]    rsp_dat;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, busy;
  logic [AW-1:0] wb_adr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_o, wb_dat_i;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  uart_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (wb_adr),
    .wb_sel_o   (wb_sel),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ack_at is the BUS cycle (1-based) the slave acks on, 0 = never.
  function automatic bit mdl_err(input int unsigned ack_at);
    return (ack_at == 0) || (ack_at > TO);
  endfunction

  function automatic int unsigned mdl_cyc_len(input int unsigned ack_at);
    return mdl_err(ack_at) ? TO : ack_at;
  endfunction

  function automatic logic [3:0] mdl_sel(input logic [AW-1:0] adr);
    int unsigned k;
    k = adr % 4;
    return 4'(1 << k);
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic we, input logic [7:0] d);
    return we ? {d, d, d, d} : 32'h0;
  endfunction

  function automatic logic [7:0] mdl_rsp_dat(input logic we, input logic [AW-1:0] adr,
                                             input logic [31:0] rdata, input int unsigned ack_at);
    int unsigned k;
    if (we || mdl_err(ack_at)) return 8'h00;
    k = adr % 4;
    return 8'((rdata >> (8 * k)) & 32'hFF);
  endfunction

  // Every rising edge of cyc after the first access must follow >= 2 low cycles.
  logic        cyc_prev = 1'b0;
  int unsigned low_run = 0;
  bit          seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen     <= 1'b0;
      low_run  <= 0;
      cyc_prev <= 1'b0;
    end else begin
      if (wb_cyc && !cyc_prev && seen) check_eq("cyc_gap", 32'(low_run >= 2), 1);
      if (wb_cyc) begin
        seen    <= 1'b1;
        low_run <= 0;
      end else begin
        low_run <= low_run + 1;
      end
      cyc_prev <= wb_cyc;
    end
  end

  task automatic do_access(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                           input int unsigned ack_at, input logic [31:0] rdata,
                           input int unsigned rsp_hold, input bit hold_valid);
    int unsigned guard;
    int unsigned n;
    logic [7:0]  e_dat;
    logic        e_err;
    e_dat = mdl_rsp_dat(we, adr, rdata, ack_at);
    e_err = mdl_err(ack_at);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      step();
      guard++;
    end
    check_eq("cmd_ready", 32'(cmd_ready), 1);
    step();
    if (!hold_valid) cmd_valid = 1'b0;
    check_eq("cyc_rise", 32'(wb_cyc), 1);
    n = 0;
    while (wb_cyc && n < 64) begin
      n++;
      check_eq("stb", 32'(wb_stb), 1);
      check_eq("sel", 32'(wb_sel), 32'(mdl_sel(adr)));
      check_eq("we", 32'(wb_we), 32'(we));
      check_eq("adr", 32'(wb_adr), 32'(adr));
      check_eq("dat_o", wb_dat_o, mdl_wdata(we, dat));
      check_eq("bus_cmd_ready", 32'(cmd_ready), 0);
      check_eq("bus_rsp_valid", 32'(rsp_valid), 0);
      check_eq("bus_busy", 32'(busy), 1);
      wb_ack   = (n == ack_at);
      wb_dat_i = (n == ack_at) ? rdata : $urandom();
      step();
    end
    wb_ack = 1'b0;
    check_eq("cyc_len", n, mdl_cyc_len(ack_at));
    check_eq("rsp_valid", 32'(rsp_valid), 1);
    check_eq("rsp_dat", 32'(rsp_dat), 32'(e_dat));
    check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
    for (int i = 0; i < int'(rsp_hold); i++) begin
      rsp_ready = 1'b0;
      wb_ack    = 1'($urandom_range(0, 1));
      step();
      check_eq("hold_valid", 32'(rsp_valid), 1);
      check_eq("hold_dat", 32'(rsp_dat), 32'(e_dat));
      check_eq("hold_err", 32'(rsp_err), 32'(e_err));
      check_eq("hold_cyc", 32'(wb_cyc), 0);
      check_eq("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    wb_ack    = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 0);
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    wb_ack    = 1'b0;
    wb_dat_i  = '0;
    #1;
    check_eq("rst_cyc", 32'(wb_cyc), 0);
    check_eq("rst_stb", 32'(wb_stb), 0);
    check_eq("rst_sel", 32'(wb_sel), 0);
    check_eq("rst_dat_o", wb_dat_o, 0);
    check_eq("rst_adr", 32'(wb_adr), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) step();
    check_eq("rst_cmd_ready_held", 32'(cmd_ready), 0);
    rst_n = 1'b1;
    check_eq("rel_cmd_ready_pre", 32'(cmd_ready), 0);
    step();
    check_eq("rel_cmd_ready", 32'(cmd_ready), 1);

    // Directed: write, read, timeouts, backpressure.
    do_access(1'b1, 5'h03, 8'h83, 2, 32'h0, 0, 1'b0);
    do_access(1'b0, 5'h05, 8'h00, 1, 32'h0000_6000, 0, 1'b0);
    do_access(1'b0, 5'h06, 8'h00, 0, 32'h1234_5678, 0, 1'b0);
    do_access(1'b1, 5'h01, 8'h5A, 1, 32'h0, 0, 1'b0);
    do_access(1'b0, 5'h06, 8'h00, TO, 32'h1234_5678, 0, 1'b0);
    do_access(1'b0, 5'h00, 8'h00, 3, 32'hCAFE_F00D, 5, 1'b0);

    // Stray ack in IDLE must not provoke anything.
    for (int i = 0; i < 3; i++) begin
      wb_ack = 1'b1;
      step();
      check_eq("stray_rsp", 32'(rsp_valid), 0);
      check_eq("stray_cyc", 32'(wb_cyc), 0);
      check_eq("stray_busy", 32'(busy), 0);
    end
    wb_ack = 1'b0;

    // Three back-to-back commands with cmd_valid held high.
    do_access(1'b0, 5'h0B, 8'h00, 2, 32'hA1B2_C3D4, 1, 1'b1);
    do_access(1'b1, 5'h0E, 8'hE7, 1, 32'h0, 2, 1'b1);
    do_access(1'b0, 5'h11, 8'h00, 4, 32'h0BAD_BEEF, 0, 1'b0);

    // Randomized accesses; ack positions beyond TO exercise the timeout path.
    for (int t = 0; t < 24; t++) begin
      do_access(1'($urandom_range(0, 1)), AW'($urandom()), 8'($urandom()),
                $urandom_range(0, TO + 4), $urandom(), $urandom_range(0, 4), 1'b0);
    end

    // Reset in the middle of a bus cycle.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 5'h09;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    check_eq("mid_stb_before", 32'(wb_stb), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_cyc", 32'(wb_cyc), 0);
    check_eq("mid_stb", 32'(wb_stb), 0);
    check_eq("mid_rsp_valid", 32'(rsp_valid), 0);
    check_eq("mid_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_eq("mid_rel_ready", 32'(cmd_ready), 1);
    do_access(1'b0, 5'h02, 8'h00, 2, 32'h00C4_0000, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
